// File: rtl/grey_conv_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : grey_arb_pkg
//  Brief    : Shared defaults, FSM state encoding and id-width helper for the
//             shared binary-to-Gray converter.
//  Revision : 1.0  initial release
// ============================================================================
package grey_arb_pkg;

  localparam int c_default_nreq = 2;
  localparam int c_default_w    = 3;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Width of a requester index; a single requester still gets one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/grey_conv_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : grey_conv_arb_if
//  Brief    : Request/result bus of grey_conv_arb. out_par exists only when
//             GREY_CONV_ARB_PARITY_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface grey_conv_arb_if #(
  parameter int NREQ = grey_arb_pkg::c_default_nreq,
  parameter int W    = grey_arb_pkg::c_default_w
);
  import grey_arb_pkg::*;

  localparam int IDW = id_width(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_bin;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [W-1:0]      out_grey;
  logic [IDW-1:0]    out_id;
  logic              out_ready;
`ifdef GREY_CONV_ARB_PARITY_EN
  logic              out_par;
`endif

  modport master (
`ifdef GREY_CONV_ARB_PARITY_EN
    input  out_par,
`endif
    output req_valid, req_bin, out_ready,
    input  req_ready, out_valid, out_grey, out_id
  );

  modport slave (
`ifdef GREY_CONV_ARB_PARITY_EN
    output out_par,
`endif
    input  req_valid, req_bin, out_ready,
    output req_ready, out_valid, out_grey, out_id
  );

endinterface
`default_nettype wire

// File: rtl/grey_conv_arb_bin_grey_core.sv
`default_nettype none
// ============================================================================
//  Module   : bin_grey_core
//  Brief    : Purely combinational W-bit binary-to-Gray conversion.
//  Revision : 1.0  initial release
// ============================================================================
module bin_grey_core #(
  parameter int W = grey_arb_pkg::c_default_w
) (
  input  logic [W-1:0] i_bin,
  output logic [W-1:0] o_grey
);

  assign o_grey = i_bin ^ (i_bin >> 1);

endmodule
`default_nettype wire

// File: rtl/grey_conv_arb.sv
`default_nettype none
// ============================================================================
//  Module   : grey_conv_arb
//  Brief    : Round-robin arbiter sharing one binary-to-Gray converter among
//             NREQ requesters, with a single registered output stage.
//             Optional registered parity output: GREY_CONV_ARB_PARITY_EN.
//  Revision : 1.0  initial release
// ============================================================================
module grey_conv_arb #(
  parameter int NREQ = grey_arb_pkg::c_default_nreq,
  parameter int W    = grey_arb_pkg::c_default_w
) (
  input  logic           clk,
  input  logic           rst,
  grey_conv_arb_if.slave bus
);
  import grey_arb_pkg::*;

  localparam int c_idw = id_width(NREQ);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_idw-1:0]  r_rr_ptr;
  logic [c_idw-1:0]  r_out_id;
  logic [c_idw-1:0]  w_gnt_idx;
  logic [c_idw-1:0]  w_ptr_nxt;
  logic [W-1:0]      r_out_grey;
  logic [W-1:0]      w_sel_bin;
  logic [W-1:0]      w_conv;
  logic [NREQ-1:0]   w_gnt_oh;
  logic [2*NREQ-1:0] w_rot;
  int                w_sum;
  logic              w_found;
  logic              w_can_load;
  logic              w_load;

  // Rotate the valid vector so rr_ptr lands at bit 0; the lowest set bit wins.
  always_comb begin : p_arb
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_sum     = 0;
    w_rot     = {bus.req_valid, bus.req_valid} >> r_rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_sum = int'(r_rr_ptr) + k;
        if (w_sum >= NREQ) begin
          w_sum = w_sum - NREQ;
        end
        w_gnt_idx = c_idw'(w_sum);
        w_found   = 1'b1;
      end
    end
  end

  always_comb begin : p_mux
    w_gnt_oh  = '0;
    w_sel_bin = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_gnt_oh[i] = w_found && (w_gnt_idx == c_idw'(i));
      if (w_gnt_oh[i]) begin
        w_sel_bin = bus.req_bin[i*W +: W];
      end
    end
  end

  bin_grey_core #(.W(W)) u_core (
    .i_bin  (w_sel_bin),
    .o_grey (w_conv)
  );

  assign w_can_load    = (r_state == ST_EMPTY) || bus.out_ready;
  assign w_load        = w_found && w_can_load;
  assign w_ptr_nxt     = (w_gnt_idx == c_idw'(NREQ - 1)) ? '0 : w_gnt_idx + c_idw'(1);
  assign bus.req_ready = w_gnt_oh & {NREQ{w_can_load && !rst}};

  always_comb begin : p_fsm_nxt
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_found) w_state_nxt = ST_FULL;
      ST_FULL:  if (bus.out_ready && !w_found) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin : p_fsm_reg
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : p_out_reg
    if (rst) begin
      r_out_grey <= '0;
      r_out_id   <= '0;
      r_rr_ptr   <= '0;
    end else if (w_load) begin
      r_out_grey <= w_conv;
      r_out_id   <= w_gnt_idx;
      r_rr_ptr   <= w_ptr_nxt;
    end
  end

  assign bus.out_valid = (r_state == ST_FULL);
  assign bus.out_grey  = r_out_grey;
  assign bus.out_id    = r_out_id;

`ifdef GREY_CONV_ARB_PARITY_EN
  logic r_out_par;

  always_ff @(posedge clk or posedge rst) begin : p_par_reg
    if (rst) begin
      r_out_par <= 1'b0;
    end else if (w_load) begin
      r_out_par <= ^w_conv;
    end
  end

  assign bus.out_par = r_out_par;
`endif

endmodule
`default_nettype wire

// File: tb/tb_grey_conv_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_grey_conv_arb
//  Brief    : Directed self-checking bench for grey_conv_arb (NREQ=2, W=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_grey_conv_arb;

  localparam int NREQ = 2;
  localparam int W    = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  logic [2:0] gtab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
  logic       ptab [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  grey_conv_arb_if #(.NREQ(NREQ), .W(W)) bus ();

  grey_conv_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] v, input logic [2:0] b0, input logic [2:0] b1);
    bus.req_valid = v;
    bus.req_bin   = {b1, b0};
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [2:0] g, input logic id);
    check_value({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    check_value({tag, ".grey"},  32'(bus.out_grey),  32'(g));
    check_value({tag, ".id"},    32'(bus.out_id),    32'(id));
  endtask

  initial begin
    rst           = 1'b1;
    bus.out_ready = 1'b0;
    set_req(2'b11, 3'b101, 3'b011);
    tick();
    tick();
    check_out("rst_init", 1'b0, 3'b000, 1'b0);
    check_value("rst_init.rdy", 32'(bus.req_ready), 32'b00);

    set_req(2'b00, 3'b000, 3'b000);
    bus.out_ready = 1'b1;
    rst           = 1'b0;
    tick();

    // Single request from requester 0.
    set_req(2'b01, 3'b101, 3'b000);
    #1 check_value("single.rdy", 32'(bus.req_ready), 32'b01);
    tick();
    check_out("single", 1'b1, 3'b111, 1'b0);
    set_req(2'b00, 3'b000, 3'b000);
    tick();
    check_out("idle_hold", 1'b0, 3'b111, 1'b0);

    // Pointer now at 1: requester 1 wins a tie.
    set_req(2'b11, 3'b110, 3'b000);
    #1 check_value("ptr1.rdy", 32'(bus.req_ready), 32'b10);
    tick();
    check_out("ptr1", 1'b1, 3'b000, 1'b1);
    set_req(2'b00, 3'b000, 3'b000);
    tick();

    // Contention from pointer 0.
    set_req(2'b11, 3'b110, 3'b011);
    #1 check_value("cont.rdy0", 32'(bus.req_ready), 32'b01);
    tick();
    check_out("cont.c1", 1'b1, 3'b101, 1'b0);
    #1 check_value("cont.rdy1", 32'(bus.req_ready), 32'b10);
    tick();
    check_out("cont.c2", 1'b1, 3'b010, 1'b1);
    set_req(2'b00, 3'b000, 3'b000);
    tick();
    check_value("cont.drain", 32'(bus.out_valid), 32'b0);

    // Fairness: alternating grants while both stay valid.
    set_req(2'b11, 3'b110, 3'b011);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_out($sformatf("fair%0d", i), 1'b1, (i % 2 == 1) ? 3'b010 : 3'b101, 1'(i % 2));
    end
    set_req(2'b00, 3'b000, 3'b000);
    tick();

    // Backpressure.
    set_req(2'b01, 3'b111, 3'b000);
    tick();
    check_out("bp.load", 1'b1, 3'b100, 1'b0);
    bus.out_ready = 1'b0;
    set_req(2'b11, 3'b111, 3'b001);
    #1 check_value("bp.rdy", 32'(bus.req_ready), 32'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("bp.hold%0d", i), 1'b1, 3'b100, 1'b0);
      check_value($sformatf("bp.rdy%0d", i), 32'(bus.req_ready), 32'b00);
    end
    bus.out_ready = 1'b1;
    #1 check_value("bp.rel_rdy", 32'(bus.req_ready), 32'b10);
    tick();
    check_out("bp.rel", 1'b1, 3'b001, 1'b1);
    set_req(2'b00, 3'b000, 3'b000);
    tick();
    check_value("bp.drain", 32'(bus.out_valid), 32'b0);

    // Sweep all codes through requester 1.
    for (int b = 0; b < 8; b++) begin
      set_req(2'b10, 3'b000, 3'(b));
      tick();
      check_out($sformatf("sweep%0d", b), 1'b1, gtab[b], 1'b1);
`ifdef GREY_CONV_ARB_PARITY_EN
      check_value($sformatf("sweep%0d.par", b), 32'(bus.out_par), 32'(ptab[b]));
`endif
    end
    set_req(2'b00, 3'b000, 3'b000);
    tick();

    // Reset mid-stream with a pending result and pointer at 1.
    set_req(2'b01, 3'b101, 3'b000);
    tick();
    check_out("mid.pre", 1'b1, 3'b111, 1'b0);
    rst = 1'b1;
    #1;
    check_out("mid.rst", 1'b0, 3'b000, 1'b0);
    check_value("mid.rst_rdy", 32'(bus.req_ready), 32'b00);
`ifdef GREY_CONV_ARB_PARITY_EN
    check_value("mid.rst_par", 32'(bus.out_par), 32'b0);
`endif
    tick();
    check_out("mid.rst_hold", 1'b0, 3'b000, 1'b0);
    set_req(2'b11, 3'b101, 3'b010);
    rst = 1'b0;
    #1 check_value("mid.ptr0_rdy", 32'(bus.req_ready), 32'b01);
    tick();
    check_out("mid.post", 1'b1, 3'b111, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
